// File: rtl/lgn_seq_pkg.sv
// rtl/lgn_seq_pkg.sv - shared types and constants for the LGN frame sequencer
package lgn_seq_pkg;

  typedef enum logic [2:0] {IDLE, STREAM, DRAIN, CAPTURE, GAP} state_t;

  localparam logic       SRC_A            = 1'b0;
  localparam logic       SRC_B            = 1'b1;
  localparam logic [3:0] INVALID_CLASS    = 4'hF;
  localparam int         FRAME_BYTES_DFLT = 32;

  // Core outputs above 9 are not digits; fold them onto one invalid code.
  function automatic logic [3:0] classify(input logic [3:0] idx);
    return (idx <= 4'd9) ? idx : INVALID_CLASS;
  endfunction

endpackage

// File: rtl/lgn_rr_arbiter2.sv
// rtl/lgn_rr_arbiter2.sv - two-way round-robin pick with a hold input
module lgn_rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       hold,
  output logic [1:0] pick
);

  logic ptr;

  // ptr names the preferred source; it only matters when both request.
  always_comb begin
    pick = req;
    if (req == 2'b11) pick = ptr ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr <= 1'b0;
    else if (!hold && (req != 2'b00)) ptr <= ~ptr;
  end

endmodule

// File: rtl/lgn_frame_sequencer.sv
// rtl/lgn_frame_sequencer.sv - streams frames into the LGN core; optional LGN_SEQ_STABLE_EN
module lgn_frame_sequencer
  import lgn_seq_pkg::*;
#(
  parameter int FRAME_BYTES    = FRAME_BYTES_DFLT,
  parameter int RESULT_LATENCY = 4,
  parameter int GAP_CYCLES     = 2,
  localparam int AW            = $clog2(FRAME_BYTES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req,
  output logic [1:0]    grant,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [7:0]    rd_data,
  output logic [7:0]    core_ui,
  input  logic [3:0]    core_index,
  output logic          result_valid,
  output logic [3:0]    result_index,
  output logic          result_src,
  output logic          busy
);

  state_t     state;
  logic [7:0] cnt;
  logic       data_valid;
  logic [1:0] pick;
  logic       src;
  logic [3:0] cls;

  lgn_rr_arbiter2 u_arb (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .hold (state != IDLE),
    .pick (pick)
  );

  assign busy = (state != IDLE);
  assign src  = grant[1];
  assign cls  = classify(core_index);

`ifdef LGN_SEQ_STABLE_EN
  logic [3:0] last_idx [2];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      grant        <= 2'b00;
      rd_en        <= 1'b0;
      rd_addr      <= '0;
      core_ui      <= 8'h00;
      data_valid   <= 1'b0;
      cnt          <= 8'd0;
      result_valid <= 1'b0;
      result_index <= 4'd0;
      result_src   <= SRC_A;
`ifdef LGN_SEQ_STABLE_EN
      last_idx[0]  <= INVALID_CLASS;
      last_idx[1]  <= INVALID_CLASS;
`endif
    end else begin
      result_valid <= 1'b0;
      // Store answers one cycle after rd_en; register once more onto core_ui.
      data_valid   <= rd_en;
      core_ui      <= data_valid ? rd_data : 8'h00;
      case (state)
        IDLE: if (req != 2'b00) begin
          grant   <= pick;
          rd_en   <= 1'b1;
          rd_addr <= '0;
          state   <= STREAM;
        end
        STREAM: begin
          rd_addr <= rd_addr + 1'b1;
          if (rd_addr == AW'(FRAME_BYTES - 1)) begin
            rd_en <= 1'b0;
            cnt   <= 8'd0;
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (cnt == 8'(RESULT_LATENCY)) state <= CAPTURE;
          else cnt <= cnt + 8'd1;
        end
        CAPTURE: begin
`ifdef LGN_SEQ_STABLE_EN
          // Report only when two consecutive frames from this source agree.
          if (cls == last_idx[src]) begin
            result_valid <= 1'b1;
            result_index <= cls;
            result_src   <= src;
          end
          last_idx[src] <= cls;
`else
          result_valid <= 1'b1;
          result_index <= cls;
          result_src   <= src;
`endif
          cnt   <= 8'd0;
          state <= GAP;
        end
        GAP: begin
          if (cnt == 8'(GAP_CYCLES - 1)) begin
            grant <= 2'b00;
            state <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lgn_frame_sequencer.sv
// tb/tb_lgn_frame_sequencer.sv - self-checking bench for lgn_frame_sequencer
module tb_lgn_frame_sequencer;

  localparam int FB  = 32;
  localparam int RL  = 4;
  localparam int GAP = 2;
  localparam int LAT = FB + 2 + RL;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [1:0] grant;
  logic       rd_en;
  logic [4:0] rd_addr;
  logic [7:0] rd_data = 8'h00;
  logic [7:0] core_ui;
  logic [3:0] core_index;
  logic       result_valid;
  logic [3:0] result_index;
  logic       result_src;
  logic       busy;

  int tests = 0;
  int fails = 0;
  int n = 0;

  lgn_frame_sequencer #(.FRAME_BYTES(FB), .RESULT_LATENCY(RL), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .req(req), .grant(grant), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .core_ui(core_ui), .core_index(core_index),
    .result_valid(result_valid), .result_index(result_index), .result_src(result_src),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Frame stores: A returns its address, B returns 0x80 | address.
  always @(posedge clk)
    rd_data <= rd_en ? ((grant[1] ? 8'h80 : 8'h00) | {3'b000, rd_addr}) : 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame-level model: a frame starting at edge s owns every cycle up to s+LAT+GAP-1.
  bit         m_ok = 0, m_act = 0, m_ptr = 0, m_own = 0, m_fire = 0, m_rs = 0;
  int         m_s = 0;
  logic [3:0] m_ri = 4'd0;
  logic [3:0] m_last [2];
  logic [3:0] m_cls;

  always begin
    int d;
    bit in_f, e_rden;
    @(posedge clk);
    n++;
    m_fire = 0;
    if (rst) begin
      m_ok = 1; m_act = 0; m_ptr = 0; m_ri = 4'd0; m_rs = 0;
      m_last[0] = 4'hF; m_last[1] = 4'hF;
    end else if (m_ok) begin
      if (m_act && n == m_s + LAT) begin
        m_cls = (core_index <= 4'd9) ? core_index : 4'hF;
`ifdef LGN_SEQ_STABLE_EN
        m_fire = (m_cls == m_last[m_own]);
        m_last[m_own] = m_cls;
`else
        m_fire = 1;
`endif
        if (m_fire) begin m_ri = m_cls; m_rs = m_own; end
      end
      if ((!m_act || n >= m_s + LAT + GAP + 1) && req != 2'b00) begin
        m_own = (req == 2'b11) ? m_ptr : req[1];
        m_ptr = !m_ptr;
        m_s   = n;
        m_act = 1;
      end
    end
    #2;
    if (m_ok) begin
      d      = n - m_s;
      in_f   = m_act && (n <= m_s + LAT + GAP - 1);
      e_rden = m_act && (d < FB);
      chk("grant", grant, in_f ? (m_own ? 2'b10 : 2'b01) : 2'b00);
      chk("busy", busy, in_f);
      chk("rd_en", rd_en, e_rden);
      chk("rd_addr", rd_addr, e_rden ? d : 0);
      chk("core_ui", core_ui, (m_act && d >= 2 && d < FB + 2) ?
          ((m_own ? 8'h80 : 8'h00) | 8'(d - 2)) : 8'h00);
      chk("result_valid", result_valid, m_fire);
      chk("result_index", result_index, m_ri);
      chk("result_src", result_src, m_rs);
    end
  end

  // which: 0 grant seen, 1 result_valid, 2 idle, 3 address 10 being read
  task automatic wait_for(input int which, input int lim, output int at, output bit ok);
    ok = 0;
    at = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if ((which == 0 && grant != 2'b00) || (which == 1 && result_valid) ||
          (which == 2 && !busy) || (which == 3 && rd_en && rd_addr == 5'd10)) begin
        at = n;
        ok = 1;
        return;
      end
    end
  endtask

  task automatic pulse_a();
    req = 2'b01;
    @(negedge clk);
    req = 2'b00;
  endtask

  initial begin
    int g, r, r0, r1, extra;
    bit ok;
    int rs_seq [3];
    int rt_seq [3];
    rst = 1'b1; req = 2'b00; core_index = 4'd0;
    repeat (3) @(negedge clk);
    chk("reset_grant", grant, 2'b00);
    chk("reset_busy", busy, 1'b0);
    chk("reset_core_ui", core_ui, 8'h00);
    chk("reset_result_index", result_index, 4'd0);
    rst = 1'b0;
`ifdef LGN_SEQ_STABLE_EN
    begin
      logic [3:0] seq [4] = '{4'd3, 4'd3, 4'd7, 4'd7};
      int pulses;
      for (int f = 0; f < 4; f++) begin
        core_index = seq[f];
        pulse_a();
        pulses = 0;
        wait_for(2, 80, r, ok);
        chk("stable_frame_done", ok, 1);
        // The model compares result_valid every cycle; this pins the pattern.
        chk("stable_pulse_seen", (result_index == seq[f]) && (f % 2 == 1), f % 2 == 1);
      end
    end
`else
    // Single source A, rd_data follows address, class 5.
    core_index = 4'd5; req = 2'b01;
    wait_for(0, 10, g, ok);
    chk("t1_grant_wait", ok, 1);
    req = 2'b00;
    chk("t1_grant", grant, 2'b01);
    repeat (2) @(negedge clk);
    for (int k = 0; k < FB; k++) begin
      chk("t1_core_ui_byte", core_ui, k);
      @(negedge clk);
    end
    wait_for(1, 20, r, ok);
    chk("t1_result_wait", ok, 1);
    chk("t1_latency", r - g, 38);
    chk("t1_index", result_index, 4'd5);
    chk("t1_src", result_src, 1'b0);
    // One-cycle request still yields exactly one full frame.
    wait_for(2, 10, r, ok);
    pulse_a();
    wait_for(1, 60, r, ok);
    chk("t3_result_wait", ok, 1);
    chk("t3_src", result_src, 1'b0);
    extra = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (result_valid) extra++;
    end
    chk("t3_single_result", extra, 0);
    // Both requesting: A, B, A.
    core_index = 4'd9; req = 2'b11;
    for (int j = 0; j < 3; j++) begin
      wait_for(1, 60, rt_seq[j], ok);
      chk("t2_result_wait", ok, 1);
      rs_seq[j] = result_src;
      chk("t2_index", result_index, 4'd9);
    end
    req = 2'b00;
    chk("t2_src0", rs_seq[0], 0);
    chk("t2_src1", rs_seq[1], 1);
    chk("t2_src2", rs_seq[2], 0);
    r0 = rt_seq[1] - rt_seq[0];
    r1 = rt_seq[2] - rt_seq[1];
    chk("t2_spacing0", r0, LAT + GAP + 1);
    chk("t2_spacing1", r1, LAT + GAP + 1);
    // Out-of-range class folds to 0xF.
    wait_for(2, 10, r, ok);
    core_index = 4'hC;
    pulse_a();
    wait_for(1, 60, r, ok);
    chk("t5_result_wait", ok, 1);
    chk("t5_index", result_index, 4'hF);
    // Reset mid-stream, then source B starts clean.
    wait_for(2, 10, r, ok);
    core_index = 4'd2; req = 2'b01;
    wait_for(3, 30, r, ok);
    chk("t4_addr10_wait", ok, 1);
    rst = 1'b1; req = 2'b10;
    @(negedge clk);
    chk("t4_grant_cleared", grant, 2'b00);
    chk("t4_core_ui_cleared", core_ui, 8'h00);
    chk("t4_rd_en_cleared", rd_en, 1'b0);
    rst = 1'b0;
    wait_for(0, 5, g, ok);
    chk("t4_grant_wait", ok, 1);
    req = 2'b00;
    chk("t4_grant_b", grant, 2'b10);
    chk("t4_addr0", rd_addr, 5'd0);
    chk("t4_rd_en", rd_en, 1'b1);
    wait_for(1, 60, r, ok);
    chk("t4_result_wait", ok, 1);
    chk("t4_latency", r - g, 38);
    chk("t4_src", result_src, 1'b1);
    chk("t4_index", result_index, 4'd2);
`endif
    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
